mult_share_arbiter: RTL and testbench
=====================================

# mult_share_arbiter

Round-robin arbiter that shares one sequential 4x4 shift-add multiplier among NREQ requesters. It grants one requester at a time and latches that requester's operands onto the multiplier inputs. It launches the multiplier by pulsing the multiplier's synchronous reset, waits for the multiplier's sticky done, and returns the 8-bit product to the granted requester with a one-cycle valid pulse. It sits between the requesting datapath blocks and the single multiplier instance.

## Interface
- NREQ, 4, number of requesters (2..8)
- W, 4, operand width; product width is 2*W
- TIMEOUT, 31, max WAIT cycles before abort (must exceed multiplier latency; nominal ≈10)
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- req  in  NREQ  per-requester request level
- a_in  in  NREQ*W  operand A, requester i at bits [i*W +: W]
- b_in  in  NREQ*W  operand B, same packing
- gnt  out  NREQ  one-hot grant
- res_valid  out  NREQ  one-cycle result strobe to the granted requester
- result  out  2*W  product, valid when any res_valid bit is set
- busy  out  1  high in any state other than IDLE
- err  out  1  sticky timeout flag, cleared only by rst
- m_rst  out  1  synchronous reset/launch to the multiplier
- m_a, m_b  out  W  multiplier operands (registered)
- m_product  in  2*W  multiplier product
- m_done  in  1  multiplier done (sticky until next m_rst)

## Operation
- States: IDLE, LAUNCH, WAIT, DELIVER.
- IDLE:
  - If any req is set, select the first set bit searching from ptr upward with wrap.
  - Register gnt one-hot and latch that requester's a/b into m_a/m_b.
  - Go to LAUNCH.
  - If no req is set, stay in IDLE.
- LAUNCH (1 cycle): m_rst=1. Go to WAIT and clear wait_cnt.
- WAIT:
  - m_rst=0 and wait_cnt increments each cycle.
  - m_done is ignored while wait_cnt<2, because the multiplier's done clears only after its idle state executes.
  - If m_done=1 and wait_cnt>=2: capture result<=m_product and go to DELIVER.
  - If wait_cnt==TIMEOUT: set result<=0 and err<=1, then go to DELIVER.
- DELIVER (1 cycle):
  - res_valid[granted] is high.
  - Set ptr<=(granted index+1) mod NREQ.
  - Clear gnt and return to IDLE.
- gnt stays stable from LAUNCH through DELIVER inclusive.
- m_a/m_b are held constant from LAUNCH until the next grant.
- Requester rule: hold req, a_in and b_in stable until res_valid. A req drop mid-operation does not abort; the result is still delivered and the strobe is simply ignored.
- Requests arriving during busy are not seen until IDLE.
- A requester re-asserting req in its own DELIVER cycle gets lower priority than the other pending requesters, because ptr has already advanced.
- Arithmetic: the product is unsigned with 2*W bits and no truncation. The arbiter does not modify the product.

## Timing
- Reset values:
  - state=IDLE, ptr=0.
  - gnt=0, res_valid=0, result=0, busy=0, err=0.
  - m_a=0, m_b=0.
  - m_rst=1 while rst is high (m_rst = rst | LAUNCH).
- Latency:
  - Cycle 0: req is sampled in IDLE.
  - Cycle 1: LAUNCH, with gnt and m_rst high.
  - WAIT lasts until m_done is qualified.
  - DELIVER follows 1 cycle after the qualified m_done.
  - Total is multiplier latency + 3 cycles.
- Back-to-back: after DELIVER, one IDLE cycle occurs before the next LAUNCH.
- rst mid-operation: everything returns to reset values next edge. No res_valid is emitted. The multiplier is held in reset through m_rst.
- Simultaneous m_done and timeout in the same cycle: m_done wins, err is not set.

## Test plan
- Single request: requester 1, a=7, b=9 -> gnt=0010 at LAUNCH; res_valid=0010 with result=63 (0x3F) exactly one cycle; busy low next cycle.
- Four simultaneous requests with ptr=0: (15,15), (0,13), (3,5), (8,2) -> grants in order 0,1,2,3; results 225, 0, 15, 16; each gnt stays one-hot and stable per transaction.
- Round-robin fairness: req0 held continuously and req2 pulsed during requester 0's operation -> the next grant goes to 2, not 0.
- Stale done: a multiplier model holding done=1 from the previous op must not cause early DELIVER; result equals the new product (e.g. 6*6=36, not the prior value).
- Timeout: m_done tied low -> DELIVER after TIMEOUT WAIT cycles with result=0, err=1 staying high until rst, and the next request still served.
- Reset mid-WAIT: assert rst for 1 cycle -> gnt=0, no res_valid, m_rst=1 during rst, busy=0; a fresh request then completes normally.

Source files
------------

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one sequential multiplier among NREQ requesters.
// Grants one requester, launches the multiplier via m_rst, and returns the product with a one-cycle strobe.
module mult_share_arbiter #(
   parameter int NREQ    = 4,
   parameter int W       = 4,
   parameter int TIMEOUT = 31
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*W-1:0] a_in,
   input  logic [NREQ*W-1:0] b_in,
   output logic [NREQ-1:0]   gnt,
   output logic [NREQ-1:0]   res_valid,
   output logic [2*W-1:0]    result,
   output logic              busy,
   output logic              err,
   output logic              m_rst,
   output logic [W-1:0]      m_a,
   output logic [W-1:0]      m_b,
   input  logic [2*W-1:0]    m_product,
   input  logic              m_done
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LAUNCH,
      ST_WAIT,
      ST_DELIVER
   } state_t;

   state_t            state_q, state_d;
   logic [IW-1:0]     ptr_q, ptr_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [NREQ-1:0]   res_valid_q, res_valid_d;
   logic [2*W-1:0]    result_q, result_d;
   logic              err_q, err_d;
   logic [W-1:0]      m_a_q, m_a_d;
   logic [W-1:0]      m_b_q, m_b_d;
   logic [CW-1:0]     wait_cnt_q, wait_cnt_d;

   logic [W-1:0]      a_arr [NREQ];
   logic [W-1:0]      b_arr [NREQ];
   logic              sel_found;
   logic [IW-1:0]     sel_idx;

   generate
      for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
         assign a_arr[gi] = a_in[gi*W +: W];
         assign b_arr[gi] = b_in[gi*W +: W];
      end
   endgenerate

   // First set request at or above ptr, wrapping past NREQ-1 back to 0.
   always_comb begin
      logic [IW:0] cand;
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = {1'b0, ptr_q} + (IW+1)'(k);
         if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
         if (!sel_found && req[cand[IW-1:0]]) begin
            sel_found = 1'b1;
            sel_idx   = cand[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      idx_d       = idx_q;
      gnt_d       = gnt_q;
      res_valid_d = '0;
      result_d    = result_q;
      err_d       = err_q;
      m_a_d       = m_a_q;
      m_b_d       = m_b_q;
      wait_cnt_d  = wait_cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (sel_found) begin
               gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel_idx;
               idx_d   = sel_idx;
               m_a_d   = a_arr[sel_idx];
               m_b_d   = b_arr[sel_idx];
               state_d = ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            wait_cnt_d = '0;
            state_d    = ST_WAIT;
         end
         ST_WAIT: begin
            wait_cnt_d = wait_cnt_q + CW'(1);
            // The multiplier's done is still stale from the previous op for the first two cycles.
            if (m_done && (wait_cnt_q >= CW'(2))) begin
               result_d    = m_product;
               res_valid_d = gnt_q;
               state_d     = ST_DELIVER;
            end else if (wait_cnt_q == CW'(TIMEOUT)) begin
               result_d    = '0;
               err_d       = 1'b1;
               res_valid_d = gnt_q;
               state_d     = ST_DELIVER;
            end
         end
         ST_DELIVER: begin
            if (idx_q == IW'(NREQ - 1)) ptr_d = '0;
            else                        ptr_d = idx_q + IW'(1);
            gnt_d   = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         idx_q       <= '0;
         gnt_q       <= '0;
         res_valid_q <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         m_a_q       <= '0;
         m_b_q       <= '0;
         wait_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         idx_q       <= idx_d;
         gnt_q       <= gnt_d;
         res_valid_q <= res_valid_d;
         result_q    <= result_d;
         err_q       <= err_d;
         m_a_q       <= m_a_d;
         m_b_q       <= m_b_d;
         wait_cnt_q  <= wait_cnt_d;
      end
   end

   assign gnt       = gnt_q;
   assign res_valid = res_valid_q;
   assign result    = result_q;
   assign err       = err_q;
   assign m_a       = m_a_q;
   assign m_b       = m_b_q;
   assign busy      = (state_q != ST_IDLE);
   assign m_rst     = rst | (state_q == ST_LAUNCH);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter: transaction-timeline model plus a configurable multiplier stand-in.
module tb_mult_share_arbiter;
   localparam int NREQ = 4;
   localparam int W = 4;
   localparam int TIMEOUT = 31;

   logic clk = 1'b0;
   logic rst;
   logic [NREQ-1:0] req;
   logic [NREQ*W-1:0] a_in, b_in;
   logic [NREQ-1:0] gnt, res_valid;
   logic [2*W-1:0] result;
   logic busy, err, m_rst;
   logic [W-1:0] m_a, m_b;
   logic [2*W-1:0] m_product;
   logic m_done;

   always #5 clk = ~clk;

   mult_share_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
      .gnt(gnt), .res_valid(res_valid), .result(result), .busy(busy), .err(err),
      .m_rst(m_rst), .m_a(m_a), .m_b(m_b), .m_product(m_product), .m_done(m_done)
   );

   // Multiplier stand-in: done rises mul_lat cycles after m_rst drops; the old done/product
   // linger for mul_stale cycles, as in the real shift-add unit.
   int mul_lat = 8;
   int mul_stale = 1;
   bit mul_done_en = 1'b1;
   int mc = 0;
   bit prev_done = 1'b0;
   logic [7:0] prev_prod = 8'd0;
   logic [7:0] new_prod = 8'd0;

   always @(posedge clk) begin
      if (m_rst) begin
         prev_done <= m_done;
         prev_prod <= m_product;
         new_prod  <= 8'(m_a) * 8'(m_b);
         mc        <= 0;
      end else if (mc < 1000) begin
         mc <= mc + 1;
      end
   end
   assign m_done    = (mul_done_en && (mc >= mul_lat)) || ((mc < mul_stale) && prev_done);
   assign m_product = (mc >= mul_lat) ? new_prod : prev_prod;

   // Reference model: a granted transaction is LAUNCH at offset 0, WAIT at 1..kq+1, DELIVER at kq+2.
   bit md_busy = 1'b0;
   int md_off = 0, md_kq = 0, md_g = 0, md_ptr = 0;
   bit md_to = 1'b0, md_err = 1'b0;
   logic [7:0] md_result = 8'd0;
   logic [3:0] md_ma = 4'd0, md_mb = 4'd0;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (r[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return 0;
   endfunction

   task automatic model_step();
      if (rst) begin
         md_busy = 1'b0; md_ptr = 0; md_err = 1'b0; md_result = 8'd0;
         md_ma = 4'd0; md_mb = 4'd0;
      end else if (!md_busy) begin
         if (req != '0) begin
            md_g = pick(req, md_ptr);
            md_busy = 1'b1;
            md_off = 0;
            md_ma = a_in[md_g*W +: W];
            md_mb = b_in[md_g*W +: W];
            if (mul_done_en && mul_lat <= TIMEOUT) begin
               md_kq = (mul_lat < 2) ? 2 : mul_lat;
               md_to = 1'b0;
            end else begin
               md_kq = TIMEOUT;
               md_to = 1'b1;
            end
         end
      end else if (md_off == md_kq + 2) begin
         md_busy = 1'b0;
         md_ptr = (md_g + 1) % NREQ;
      end else begin
         md_off++;
         if (md_off == md_kq + 2) begin
            md_result = md_to ? 8'd0 : 8'(md_ma) * 8'(md_mb);
            if (md_to) md_err = 1'b1;
         end
      end
   endtask

   function automatic bit md_deliver();
      return md_busy && (md_off == md_kq + 2);
   endfunction

   task automatic compare();
      logic [NREQ-1:0] eg, ev;
      eg = md_busy ? (NREQ'(1) << md_g) : '0;
      ev = md_deliver() ? eg : '0;
      chk("gnt", 32'(gnt), 32'(eg));
      chk("res_valid", 32'(res_valid), 32'(ev));
      chk("busy", 32'(busy), 32'(md_busy));
      chk("m_rst", 32'(m_rst), 32'(rst || (md_busy && md_off == 0)));
      chk("err", 32'(err), 32'(md_err));
      chk("result", 32'(result), 32'(md_result));
      chk("m_a", 32'(m_a), 32'(md_ma));
      chk("m_b", 32'(m_b), 32'(md_mb));
   endtask

   task automatic step_cycle();
      model_step();
      @(negedge clk);
      cyc++;
      compare();
   endtask

   task automatic wait_rv(output logic [NREQ-1:0] rv, output logic [7:0] res);
      int n;
      n = 0;
      rv = '0;
      res = 8'd0;
      while (n < 80) begin
         step_cycle();
         n++;
         if (res_valid != '0) break;
      end
      if (res_valid == '0) begin
         total++;
         bad++;
         $display("FAIL wait_rv cyc=%0d got=no_strobe exp=strobe_within_80", cyc);
      end
      rv = res_valid;
      res = result;
   endtask

   task automatic set_ops(input int i, input int a, input int b);
      a_in[i*W +: W] = W'(a);
      b_in[i*W +: W] = W'(b);
   endtask

   task automatic rst_pulse();
      rst = 1'b1; step_cycle();
      rst = 1'b0; step_cycle();
   endtask

   logic [NREQ-1:0] rv;
   logic [7:0] res;
   int exp4 [4] = '{225, 0, 15, 16};

   initial begin
      rst = 1'b1; req = '0; a_in = '0; b_in = '0;
      repeat (3) step_cycle();
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_m_rst", 32'(m_rst), 1);
      chk("rst_result", 32'(result), 0);
      rst = 1'b0;
      step_cycle();

      // Single request
      mul_lat = 8;
      set_ops(1, 7, 9);
      req = 4'b0010;
      step_cycle();
      chk("t1_gnt_launch", 32'(gnt), 32'h2);
      chk("t1_m_rst_launch", 32'(m_rst), 1);
      wait_rv(rv, res);
      chk("t1_rv", 32'(rv), 32'h2);
      chk("t1_result", 32'(res), 63);
      req = '0;
      step_cycle();
      chk("t1_rv_one_cycle", 32'(res_valid), 0);
      chk("t1_busy_low", 32'(busy), 0);

      // Four simultaneous requests from ptr=0
      rst_pulse();
      set_ops(0, 15, 15); set_ops(1, 0, 13); set_ops(2, 3, 5); set_ops(3, 8, 2);
      req = 4'b1111;
      for (int t = 0; t < 4; t++) begin
         wait_rv(rv, res);
         chk("t2_order", 32'(rv), 32'(NREQ'(1) << t));
         chk("t2_result", 32'(res), 32'(exp4[t]));
         req = req & ~rv;
      end
      step_cycle();

      // Fairness: req0 held, req2 arrives during requester 0's op
      rst_pulse();
      set_ops(0, 2, 3);
      req = 4'b0001;
      step_cycle();
      set_ops(2, 5, 5);
      req[2] = 1'b1;
      wait_rv(rv, res);
      chk("t3_first", 32'(rv), 32'h1);
      wait_rv(rv, res);
      chk("t3_fair", 32'(rv), 32'h4);
      chk("t3_fair_res", 32'(res), 25);
      req[2] = 1'b0;
      wait_rv(rv, res);
      chk("t3_back_to_0", 32'(rv), 32'h1);
      req = '0;
      step_cycle();

      // Stale done from the previous op must not be taken
      rst_pulse();
      mul_lat = 5; mul_stale = 2;
      set_ops(3, 5, 5);
      req = 4'b1000;
      wait_rv(rv, res);
      chk("t4_first", 32'(res), 25);
      req = '0;
      repeat (4) step_cycle();
      mul_lat = 8;
      set_ops(3, 6, 6);
      req = 4'b1000;
      wait_rv(rv, res);
      chk("t4_stale", 32'(res), 36);
      req = '0;
      step_cycle();

      // Timeout with done never arriving
      mul_stale = 1; mul_done_en = 1'b0;
      set_ops(1, 3, 3);
      req = 4'b0010;
      wait_rv(rv, res);
      chk("t5_to_res", 32'(res), 0);
      chk("t5_to_err", 32'(err), 1);
      req = '0;
      step_cycle();
      mul_done_en = 1'b1; mul_lat = 6;
      set_ops(1, 4, 4);
      req = 4'b0010;
      wait_rv(rv, res);
      chk("t5_after_res", 32'(res), 16);
      chk("t5_err_sticky", 32'(err), 1);
      req = '0;
      step_cycle();

      // Reset in the middle of WAIT
      mul_lat = 10;
      set_ops(2, 9, 9);
      req = 4'b0100;
      repeat (5) step_cycle();
      rst = 1'b1;
      step_cycle();
      chk("t6_gnt", 32'(gnt), 0);
      chk("t6_busy", 32'(busy), 0);
      chk("t6_m_rst", 32'(m_rst), 1);
      chk("t6_rv", 32'(res_valid), 0);
      chk("t6_err_clr", 32'(err), 0);
      rst = 1'b0;
      wait_rv(rv, res);
      chk("t6_after", 32'(res), 81);
      req = '0;
      step_cycle();

      // done and timeout on the same cycle: done wins
      mul_lat = TIMEOUT;
      set_ops(0, 2, 7);
      req = 4'b0001;
      wait_rv(rv, res);
      chk("t7_res", 32'(res), 14);
      chk("t7_err", 32'(err), 0);
      req = '0;
      step_cycle();
      mul_lat = 8;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst = ($urandom_range(0, 299) == 0);
         if (!md_busy && $urandom_range(0, 3) == 0) begin
            int r;
            r = $urandom_range(0, 19);
            if (r == 0)      mul_lat = TIMEOUT - 1;
            else if (r == 1) mul_lat = TIMEOUT;
            else if (r == 2) mul_lat = TIMEOUT + 1;
            else             mul_lat = $urandom_range(0, 12);
            mul_done_en = ($urandom_range(0, 29) != 0);
            mul_stale = $urandom_range(1, 2);
         end
         for (int i = 0; i < NREQ; i++) begin
            if (req[i]) begin
               if (md_deliver() && md_g == i) req[i] = $urandom_range(0, 1) == 1;
               else if (md_busy && md_g == i && $urandom_range(0, 39) == 0) req[i] = 1'b0;
            end else if ($urandom_range(0, 5) == 0) begin
               set_ops(i, $urandom_range(0, 15), $urandom_range(0, 15));
               req[i] = 1'b1;
            end
         end
         step_cycle();
      end
      rst = 1'b0;
      req = '0;
      repeat (40) step_cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
